// File: rtl/lvds_tx_clk_rst_seq.sv
// Reset/lock sequencer for the LVDS 7:1 TX clock tree, clocked by the free-running PLL reference.
// Resets the rPLL, qualifies LOCK, releases the serializer, and restarts on timeout or lock loss.
module lvds_tx_clk_rst_seq #(
    parameter int unsigned RST_CYCLES        = 64,
    parameter int unsigned LOCK_TIMEOUT      = 70200,
    parameter int unsigned STABLE_CYCLES     = 1024,
    parameter int unsigned SERDES_RST_CYCLES = 16,
    parameter int unsigned CNT_W             = 24
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       serdes_rst,
    output logic       tx_ready,
    output logic [2:0] state_o,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        StPllRst     = 3'd0,
        StWaitLock   = 3'd1,
        StLockStable = 3'd2,
        StSerdesRst  = 3'd3,
        StRun        = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SerdesLast  = CNT_W'(SERDES_RST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_reset_q, serdes_rst_q, tx_ready_q;
    logic             retry_inc, lost_inc;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        retry_inc = 1'b0;
        lost_inc  = 1'b0;
        if (restart) begin
            state_d = StPllRst;
        end else begin
            case (state_q)
                StPllRst: begin
                    if (timer_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (lock_s_q) begin
                        state_d = StLockStable;
                    end else if (timer_q == TimeoutLast) begin
                        state_d   = StPllRst;
                        retry_inc = 1'b1;
                    end
                end
                StLockStable: begin
                    if (!lock_s_q)                 state_d = StWaitLock;
                    else if (timer_q == StableLast) state_d = StSerdesRst;
                end
                StSerdesRst: begin
                    if (!lock_s_q) begin
                        state_d  = StPllRst;
                        lost_inc = 1'b1;
                    end else if (timer_q == SerdesLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    timer_d = timer_q;  // no limit in RUN, so hold to avoid wrapping
                    if (!lock_s_q) begin
                        state_d  = StPllRst;
                        lost_inc = 1'b1;
                    end
                end
                default: state_d = StPllRst;
            endcase
        end
        if (restart || (state_d != state_q)) timer_d = '0;
        retry_d = (retry_inc && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;
        lost_d  = (lost_inc && (lost_q != 8'hFF)) ? lost_q + 8'd1 : lost_q;
    end

    // Outputs are decoded from the next state so they change on the same edge as state_q.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPllRst;
            timer_q      <= '0;
            retry_q      <= '0;
            lost_q       <= '0;
            pll_reset_q  <= 1'b1;
            serdes_rst_q <= 1'b1;
            tx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            pll_reset_q  <= (state_d == StPllRst);
            serdes_rst_q <= (state_d != StRun);
            tx_ready_q   <= (state_d == StRun);
        end
    end

    assign pll_reset     = pll_reset_q;
    assign serdes_rst    = serdes_rst_q;
    assign tx_ready      = tx_ready_q;
    assign state_o       = state_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule
